rd_fifo_packer: RTL and testbench

- Upstream neighbour of the read-FIFO-to-bus-master serializer.
- Accepts 16-bit flash read beats with a per-beat ECC error flag.
- Packs 8 beats into one 128-bit data word, prefixes an error code, and writes the 136-bit entry into the read FIFO, honouring FIFO full.
- One i_start transfers exactly one page of ENTRIES_PER_PAGE entries.

---
 rtl/rd_fifo_packer.sv | 179 +++++++++++++++++
 tb/tb_rd_fifo_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_fifo_packer.sv
// rd_fifo_packer
//   Packs eight 16-bit flash read beats into one 128-bit word, prefixes an
//   error code and writes the resulting entry into the read FIFO. One i_start
//   moves exactly one page of ENTRIES_PER_PAGE entries.
//
//   Optional feature macro: RD_FIFO_PACKER_ERR_STATS_EN
//     defined   -> o_err_entry_cnt counts written entries that carried at
//                  least one ECC error (saturating, cleared only by i_rst)
//     undefined -> o_err_entry_cnt is tied to zero
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             start one page transfer (honoured only when idle)
//   o_busy              high whenever the block is not idle
//   o_done              one-cycle pulse after the last entry of the page
//   i_flash_data        16-bit flash read beat
//   i_flash_valid       beat valid
//   i_flash_ecc_err     beat failed ECC (qualified by valid && ready)
//   o_flash_ready       beat can be accepted (high only while filling)
//   o_rd_fifo_data      FIFO entry {err_code, data[127:0]}
//   o_rd_fifo_we        FIFO write strobe
//   i_rd_fifo_full      FIFO full
//   o_err_entry_cnt     count of entries written with a non-zero error count
module rd_fifo_packer #(
  parameter int RD_FIFO_DATA_WIDTH = 136,
  parameter int ERROR_CODE_WIDTH   = 8,
  parameter int ENTRIES_PER_PAGE   = 256
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  input  logic [15:0]                   i_flash_data,
  input  logic                          i_flash_valid,
  input  logic                          i_flash_ecc_err,
  output logic                          o_flash_ready,
  output logic [RD_FIFO_DATA_WIDTH-1:0] o_rd_fifo_data,
  output logic                          o_rd_fifo_we,
  input  logic                          i_rd_fifo_full,
  output logic [15:0]                   o_err_entry_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PUSH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LAST_ENTRY = 16'(ENTRIES_PER_PAGE - 1);

  state_t                      state;
  state_t                      next_state;
  logic [2:0]                  beat_idx;
  logic [15:0]                 entry_cnt;
  logic [3:0]                  err_count;
  logic                        sticky;
  logic [127:0]                data_reg;
  logic [ERROR_CODE_WIDTH-1:0] err_code;
  logic                        accept;
  logic                        last_entry;

  assign accept     = i_flash_valid && o_flash_ready;
  assign last_entry = (entry_cnt == LAST_ENTRY);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    o_flash_ready = 1'b0;
    o_rd_fifo_we  = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          next_state = FILL;
        end
      end
      FILL: begin
        o_flash_ready = 1'b1;
        if (i_flash_valid && (beat_idx == 3'd7)) begin
          next_state = PUSH;
        end
      end
      PUSH: begin
        o_rd_fifo_we = !i_rd_fifo_full;
        if (!i_rd_fifo_full) begin
          next_state = last_entry ? DONE : FILL;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat k lands at data[127-16k -: 16]; {~beat_idx, 4'b0} is (7-k)*16, the
  // low bit of that slice, so beat 0 ends up in the most significant lane.
  // The per-entry error count clears whenever FILL is entered (from IDLE or
  // from PUSH); the page-sticky flag clears only on a fresh start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_idx  <= 3'd0;
      entry_cnt <= 16'd0;
      err_count <= 4'd0;
      sticky    <= 1'b0;
      data_reg  <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            beat_idx  <= 3'd0;
            entry_cnt <= 16'd0;
            err_count <= 4'd0;
            sticky    <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            data_reg[{~beat_idx, 4'b0000} +: 16] <= i_flash_data;
            beat_idx <= beat_idx + 3'd1;
            if (i_flash_ecc_err) begin
              err_count <= err_count + 4'd1;
              sticky    <= 1'b1;
            end
          end
        end
        PUSH: begin
          if (!i_rd_fifo_full) begin
            if (last_entry) begin
              entry_cnt <= 16'd0;
            end else begin
              entry_cnt <= entry_cnt + 16'd1;
              err_count <= 4'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    err_code                     = '0;
    err_code[3:0]                = err_count;
    err_code[ERROR_CODE_WIDTH-1] = sticky;
  end

  assign o_rd_fifo_data = {err_code, data_reg};

`ifdef RD_FIFO_PACKER_ERR_STATS_EN
  logic [15:0] err_entry_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_entry_cnt <= 16'd0;
    end else if (o_rd_fifo_we && (err_count != 4'd0) && (err_entry_cnt != 16'hFFFF)) begin
      err_entry_cnt <= err_entry_cnt + 16'd1;
    end
  end

  assign o_err_entry_cnt = err_entry_cnt;
`else
  assign o_err_entry_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rd_fifo_packer.sv
// tb_rd_fifo_packer
//   Self-checking bench for rd_fifo_packer. Pages of three entries are driven
//   with deterministic and random beats, valid gaps, FIFO backpressure, stray
//   i_start pulses and a mid-entry reset. Expected entries come from a
//   behavioural model that concatenates beats in arrival order, counts error
//   beats and tracks a page-level error flag.
module tb_rd_fifo_packer;

  localparam int EPP = 3;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic         o_busy;
  logic         o_done;
  logic [15:0]  i_flash_data;
  logic         i_flash_valid;
  logic         i_flash_ecc_err;
  logic         o_flash_ready;
  logic [135:0] o_rd_fifo_data;
  logic         o_rd_fifo_we;
  logic         i_rd_fifo_full;
  logic [15:0]  o_err_entry_cnt;

  int assertCount = 0;
  int failCount   = 0;
  int writeCount  = 0;
  int errEntries  = 0;
  bit pageErr     = 1'b0;

  logic [15:0] beats[8];
  logic        errs[8];

  rd_fifo_packer #(
    .RD_FIFO_DATA_WIDTH(136),
    .ERROR_CODE_WIDTH  (8),
    .ENTRIES_PER_PAGE  (EPP)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .i_flash_data   (i_flash_data),
    .i_flash_valid  (i_flash_valid),
    .i_flash_ecc_err(i_flash_ecc_err),
    .o_flash_ready  (o_flash_ready),
    .o_rd_fifo_data (o_rd_fifo_data),
    .o_rd_fifo_we   (o_rd_fifo_we),
    .i_rd_fifo_full (i_rd_fifo_full),
    .o_err_entry_cnt(o_err_entry_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Count every FIFO write the DUT issues, to catch extra or missing writes.
  always @(posedge i_clk) begin
    if (!i_rst && o_rd_fifo_we) begin
      writeCount <= writeCount + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [135:0] observed,
                             input logic [135:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int expectedErrCnt();
`ifdef RD_FIFO_PACKER_ERR_STATS_EN
    return errEntries;
`else
    return 0;
`endif
  endfunction

  // errMode: 0 = deterministic clean beats, 1 = errors on beats 2 and 5 of
  // entry 0 only, 2 = random data and random errors.
  task automatic applyStimulus(input int fullCycles, input int gapMax, input int errMode,
                               input bit startInFill, input bit startInDone);
    logic [127:0] expData;
    logic [7:0]   expCode;
    logic [135:0] expWord;
    int           eCount;
    int           n;
    int           gaps;
    int           writesBefore;

    writesBefore = writeCount;
    pageErr      = 1'b0;
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
    checkOutput("busy_after_start", 136'(o_busy), 136'(1));
    checkOutput("ready_after_start", 136'(o_flash_ready), 136'(1));

    for (int e = 0; e < EPP; e++) begin
      for (int k = 0; k < 8; k++) begin
        case (errMode)
          0: begin beats[k] = 16'(8 * e + k + 1); errs[k] = 1'b0; end
          1: begin beats[k] = 16'(8 * e + k + 1); errs[k] = (e == 0) && (k == 2 || k == 5); end
          default: begin beats[k] = 16'($urandom); errs[k] = ($urandom_range(0, 3) == 0); end
        endcase
      end

      for (int k = 0; k < 8; k++) begin
        gaps = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
        if (gaps > 0) begin
          i_flash_valid = 1'b0;
          repeat (gaps) step();
        end
        i_flash_valid   = 1'b1;
        i_flash_data    = beats[k];
        i_flash_ecc_err = errs[k];
        i_start         = startInFill && (e == 0) && (k == 3);
        if (k == 7) i_rd_fifo_full = (fullCycles > 0);
        n = 0;
        while (!o_flash_ready && n < 20) begin
          step();
          n++;
        end
        checkOutput("beat_ready", 136'(o_flash_ready), 136'(1));
        step();
        i_start = 1'b0;
      end
      i_flash_valid   = 1'b0;
      i_flash_ecc_err = 1'b0;

      expData = '0;
      eCount  = 0;
      for (int k = 0; k < 8; k++) begin
        expData = {expData[111:0], beats[k]};
        if (errs[k]) eCount++;
      end
      if (eCount != 0) pageErr = 1'b1;
      expCode = 8'(eCount) | (pageErr ? 8'h80 : 8'h00);
      expWord = {expCode, expData};

      for (int i = 0; i < fullCycles; i++) begin
        checkOutput("we_while_full", 136'(o_rd_fifo_we), 136'(0));
        checkOutput("ready_while_full", 136'(o_flash_ready), 136'(0));
        checkOutput("data_while_full", o_rd_fifo_data, expWord);
        step();
      end
      i_rd_fifo_full = 1'b0;
      #1;
      checkOutput("we_push", 136'(o_rd_fifo_we), 136'(1));
      checkOutput("entry_data", o_rd_fifo_data, expWord);
      step();
      if (eCount != 0) errEntries++;
      checkOutput("err_entry_cnt", 136'(o_err_entry_cnt), 136'(expectedErrCnt()));

      if (e < EPP - 1) begin
        checkOutput("ready_next_entry", 136'(o_flash_ready), 136'(1));
        checkOutput("no_done_mid_page", 136'(o_done), 136'(0));
      end else begin
        checkOutput("done_pulse", 136'(o_done), 136'(1));
        checkOutput("busy_in_done", 136'(o_busy), 136'(1));
        i_start = startInDone;
        step();
        i_start = 1'b0;
        checkOutput("done_cleared", 136'(o_done), 136'(0));
        checkOutput("idle_after_done", 136'(o_busy), 136'(0));
        step();
        checkOutput("done_single_pulse", 136'(o_done), 136'(0));
        checkOutput("still_idle", 136'(o_busy), 136'(0));
      end
    end
    checkOutput("writes_per_page", 136'(writeCount - writesBefore), 136'(EPP));
  endtask

  initial begin
    int writesBefore;

    i_rst           = 1'b1;
    i_start         = 1'b0;
    i_flash_data    = 16'h0000;
    i_flash_valid   = 1'b0;
    i_flash_ecc_err = 1'b0;
    i_rd_fifo_full  = 1'b0;
    repeat (3) step();
    checkOutput("reset_busy", 136'(o_busy), 136'(0));
    checkOutput("reset_done", 136'(o_done), 136'(0));
    checkOutput("reset_ready", 136'(o_flash_ready), 136'(0));
    checkOutput("reset_we", 136'(o_rd_fifo_we), 136'(0));
    checkOutput("reset_data", o_rd_fifo_data, 136'(0));
    checkOutput("reset_err_cnt", 136'(o_err_entry_cnt), 136'(0));
    i_rst = 1'b0;
    step();

    $display("[TB] clean page, no gaps");
    applyStimulus(0, 0, 0, 1'b0, 1'b0);
    $display("[TB] error pattern with backpressure");
    applyStimulus(5, 0, 1, 1'b0, 1'b0);
    $display("[TB] clean page with valid gaps");
    applyStimulus(0, 2, 0, 1'b0, 1'b0);
    $display("[TB] random page with stray starts");
    applyStimulus(2, 2, 2, 1'b1, 1'b1);

    $display("[TB] reset mid-entry");
    writesBefore = writeCount;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_flash_valid   = 1'b1;
      i_flash_data    = 16'($urandom);
      i_flash_ecc_err = (k == 1);
      step();
    end
    i_flash_valid   = 1'b0;
    i_flash_ecc_err = 1'b0;
    i_rst           = 1'b1;
    step();
    checkOutput("rst_mid_busy", 136'(o_busy), 136'(0));
    checkOutput("rst_mid_ready", 136'(o_flash_ready), 136'(0));
    checkOutput("rst_mid_we", 136'(o_rd_fifo_we), 136'(0));
    checkOutput("rst_mid_data", o_rd_fifo_data, 136'(0));
    checkOutput("rst_mid_err_cnt", 136'(o_err_entry_cnt), 136'(0));
    checkOutput("rst_mid_no_write", 136'(writeCount - writesBefore), 136'(0));
    i_rst      = 1'b0;
    errEntries = 0;
    step();
    applyStimulus(0, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
